// File: rtl/uart_rx_framed.sv
// UART receiver with majority-vote bit decisions, optional parity, one or two
// stop bits, and a show-ahead FIFO holding each word with its error flags.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  input  logic                 i_rd_en,
  output logic                 o_rd_valid,
  output logic [DATA_BITS-1:0] o_rd_data,
  output logic                 o_rd_parity_err,
  output logic                 o_rd_frame_err,
  output logic                 o_overrun
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = DATA_BITS + 2;
  localparam int H    = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(H);
  localparam logic [CW-1:0] CNT_DEC   = CW'(H + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_COMMIT
  } state_t;

  logic [1:0]           sync_reg;
  logic                 prev_reg;
  logic                 rx_sync;
  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [1:0]           samp_reg;
  logic [3:0]           bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_reg;
  logic                 frm_err_reg;
  logic                 decide;
  logic                 bit_maj;

  logic [EW-1:0]        entry_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CNTW-1:0]      count_reg;
  logic                 overrun_reg;
  logic                 commit;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic [EW-1:0]        head;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_reg <= 2'b11;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], i_uart_rx};
      prev_reg <= sync_reg[1];
    end
  end

  assign rx_sync = sync_reg[1];
  assign decide  = (cnt_reg == CNT_DEC);
  // Third vote is the live sample taken in the decision cycle itself.
  assign bit_maj = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync) |
                   (samp_reg[1] & rx_sync);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      samp_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
    end else begin
      if (state_reg == S_IDLE || state_reg == S_COMMIT || cnt_reg == CNT_LAST)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + CW'(1);

      if (cnt_reg == CNT_S0) samp_reg[0] <= rx_sync;
      if (cnt_reg == CNT_S1) samp_reg[1] <= rx_sync;

      case (state_reg)
        S_IDLE: begin
          if (prev_reg && !rx_sync) begin
            state_reg   <= S_START;
            bit_idx_reg <= '0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
          end
        end
        S_START: begin
          if (decide) state_reg <= bit_maj ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (decide) begin
            shift_reg <= {bit_maj, shift_reg[DATA_BITS-1:1]};
            if (bit_idx_reg == DATA_LAST) begin
              bit_idx_reg <= '0;
              state_reg   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (decide) begin
            par_err_reg <= (^shift_reg) ^ bit_maj ^ PAR_ODD;
            state_reg   <= S_STOP;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (!bit_maj) frm_err_reg <= 1'b1;
            if (bit_idx_reg == STOP_LAST) state_reg <= S_COMMIT;
            else bit_idx_reg <= bit_idx_reg + 4'd1;
          end
        end
        S_COMMIT: state_reg <= S_IDLE;
        default:  state_reg <= S_IDLE;
      endcase
    end
  end

  assign commit = (state_reg == S_COMMIT);
  assign full   = (count_reg == CNTW'(FIFO_DEPTH));
  assign pop    = i_rd_en && (count_reg != '0);
  // A pop in the commit cycle frees the slot the new word needs.
  assign push   = commit && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (push) entry_mem[wr_ptr_reg] <= {shift_reg, par_err_reg, frm_err_reg};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= commit && full && !pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign o_rd_valid = (count_reg != '0);
  // Gate with valid so an empty FIFO never exposes stale or unwritten slots.
  assign head = o_rd_valid ? entry_mem[rd_ptr_reg] : '0;
  assign o_rd_data       = head[EW-1:2];
  assign o_rd_parity_err = head[1];
  assign o_rd_frame_err  = head[0];
  assign o_overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: 8N1, 8E1 and 9N2 instances share one
// clock and reset; each task drives serial frames and checks the FIFO head.
module tb_uart_rx_framed;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_a, rd_a, valid_a, perr_a, ferr_a, ovr_a;
  logic [7:0] data_a;
  logic       rx_p, rd_p, valid_p, perr_p, ferr_p, ovr_p;
  logic [7:0] data_p;
  logic       rx_w, rd_w, valid_w, perr_w, ferr_w, ovr_w;
  logic [8:0] data_w;

  int vectors = 0;
  int errors  = 0;
  int ovr_cnt = 0;

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_a), .i_rd_en(rd_a), .o_rd_valid(valid_a),
    .o_rd_data(data_a), .o_rd_parity_err(perr_a), .o_rd_frame_err(ferr_a), .o_overrun(ovr_a));

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_p), .i_rd_en(rd_p), .o_rd_valid(valid_p),
    .o_rd_data(data_p), .o_rd_parity_err(perr_p), .o_rd_frame_err(ferr_p), .o_overrun(ovr_p));

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_w), .i_rd_en(rd_w), .o_rd_valid(valid_w),
    .o_rd_data(data_w), .o_rd_parity_err(perr_w), .o_rd_frame_err(ferr_w), .o_overrun(ovr_w));

  always @(negedge clk) if (ovr_a === 1'b1) ovr_cnt++;

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_w = v;
    endcase
  endtask

  // Caller must be at a negedge; returns at the negedge ending the last bit.
  task automatic drive_bits(input int which, input logic [15:0] seq, input int len);
    for (int b = 0; b < len; b++) begin
      set_line(which, seq[b]);
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_a(input logic [7:0] v);
    $display("tx 8N1 data=0x%02h", v);
    drive_bits(0, {6'h3F, 1'b1, v, 1'b0}, 10);
  endtask

  task automatic pop_a();
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_p = 1'b1; rx_w = 1'b1;
    rd_a = 1'b0; rd_p = 1'b0; rd_w = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_a); end
    vectors++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got 0x%02h want 0x00", data_a); end
    vectors++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %02b want 00", {perr_a, ferr_a}); end
    vectors++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", ovr_a); end
    vectors++; if ({valid_p, valid_w} !== 2'b00) begin errors++; $display("FAIL reset_valid_pw: got %02b want 00", {valid_p, valid_w}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [15:0] seq;
    int first;
    seq = {6'h3F, 1'b1, 8'hA5, 1'b0};
    first = 0;
    $display("tx 8N1 data=0xa5 (latency probe)");
    rx_a = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_a === 1'b1 && first == 0) first = c;
      rx_a = seq[c / CPB];
    end
    vectors++; if (first != 158) begin errors++; $display("FAIL basic_latency: got %0d want 158", first); end
    vectors++; if (data_a !== 8'hA5) begin errors++; $display("FAIL basic_data: got 0x%02h want 0xa5", data_a); end
    vectors++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %02b want 00", {perr_a, ferr_a}); end
    pop_a();
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %0b want 0", valid_a); end
  endtask

  task automatic test_parity();
    $display("tx 8E1 data=0x03 parity=1");
    drive_bits(1, {5'h1F, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    vectors++; if (valid_p !== 1'b1 || data_p !== 8'h03) begin errors++; $display("FAIL par_bad_data: got v=%0b 0x%02h want v=1 0x03", valid_p, data_p); end
    vectors++; if (perr_p !== 1'b1 || ferr_p !== 1'b0) begin errors++; $display("FAIL par_bad_flags: got p=%0b f=%0b want p=1 f=0", perr_p, ferr_p); end
    rd_p = 1'b1; @(negedge clk); rd_p = 1'b0;
    $display("tx 8E1 data=0x07 parity=1");
    drive_bits(1, {5'h1F, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    vectors++; if (valid_p !== 1'b1 || data_p !== 8'h07) begin errors++; $display("FAIL par_ok_data: got v=%0b 0x%02h want v=1 0x07", valid_p, data_p); end
    vectors++; if (perr_p !== 1'b0) begin errors++; $display("FAIL par_ok_flag: got %0b want 0", perr_p); end
    rd_p = 1'b1; @(negedge clk); rd_p = 1'b0;
    vectors++; if (valid_p !== 1'b0) begin errors++; $display("FAIL par_drain: got %0b want 0", valid_p); end
  endtask

  task automatic test_break();
    $display("tx 8N1 data=0x55 stop=0 then 30-bit break");
    drive_bits(0, {6'h00, 1'b0, 8'h55, 1'b0}, 10);
    repeat (30 * CPB) @(negedge clk);
    vectors++; if (valid_a !== 1'b1 || data_a !== 8'h55) begin errors++; $display("FAIL break_data: got v=%0b 0x%02h want v=1 0x55", valid_a, data_a); end
    vectors++; if (ferr_a !== 1'b1 || perr_a !== 1'b0) begin errors++; $display("FAIL break_flags: got f=%0b p=%0b want f=1 p=0", ferr_a, perr_a); end
    pop_a();
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL break_single_entry: got %0b want 0", valid_a); end
    rx_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_a(8'h0F);
    vectors++; if (valid_a !== 1'b1 || data_a !== 8'h0F || ferr_a !== 1'b0) begin errors++; $display("FAIL break_recover: got v=%0b 0x%02h f=%0b want v=1 0x0f f=0", valid_a, data_a, ferr_a); end
    pop_a();
  endtask

  task automatic test_glitch();
    $display("tx 3-cycle low pulse");
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL glitch_start: got %0b want 0", valid_a); end
    $display("tx 8N1 data=0x00 with 1-cycle high at data bit 3 centre");
    fork
      drive_bits(0, {6'h3F, 1'b1, 8'h00, 1'b0}, 10);
      begin
        repeat (73) @(negedge clk);
        rx_a = 1'b1;
        @(negedge clk);
        rx_a = 1'b0;
      end
    join
    vectors++; if (valid_a !== 1'b1 || data_a !== 8'h00) begin errors++; $display("FAIL glitch_vote: got v=%0b 0x%02h want v=1 0x00", valid_a, data_a); end
    pop_a();
  endtask

  task automatic test_overrun();
    int base;
    logic [7:0] exp;
    base = ovr_cnt;
    for (int i = 1; i <= 4; i++) send_a(8'(i * 8'h11));
    vectors++; if (ovr_cnt - base != 0) begin errors++; $display("FAIL ovr_early: got %0d pulses want 0", ovr_cnt - base); end
    send_a(8'h55);
    repeat (20) @(negedge clk);
    vectors++; if (ovr_cnt - base != 1) begin errors++; $display("FAIL ovr_count: got %0d pulses want 1", ovr_cnt - base); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i * 8'h11);
      vectors++; if (valid_a !== 1'b1 || data_a !== exp) begin errors++; $display("FAIL ovr_order: got v=%0b 0x%02h want v=1 0x%02h", valid_a, data_a, exp); end
      pop_a();
    end
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %0b want 0", valid_a); end
  endtask

  task automatic test_back_to_back_pop();
    int base;
    logic [7:0] exp;
    base = ovr_cnt;
    for (int i = 1; i <= 4; i++) send_a(8'(i * 8'h11));
    $display("tx 8N1 data=0x55 with pop in commit cycle");
    fork
      drive_bits(0, {6'h3F, 1'b1, 8'h55, 1'b0}, 10);
      begin
        repeat (157) @(negedge clk);
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    vectors++; if (ovr_cnt - base != 0) begin errors++; $display("FAIL pop_ovr: got %0d pulses want 0", ovr_cnt - base); end
    for (int i = 2; i <= 5; i++) begin
      exp = 8'(i * 8'h11);
      vectors++; if (valid_a !== 1'b1 || data_a !== exp) begin errors++; $display("FAIL pop_order: got v=%0b 0x%02h want v=1 0x%02h", valid_a, data_a, exp); end
      pop_a();
    end
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL pop_drain: got %0b want 0", valid_a); end
  endtask

  task automatic test_reset_mid();
    send_a(8'h81);
    vectors++; if (valid_a !== 1'b1 || data_a !== 8'h81) begin errors++; $display("FAIL mid_preload: got v=%0b 0x%02h want v=1 0x81", valid_a, data_a); end
    $display("tx 8N1 data=0xff with reset at bit 4");
    fork
      drive_bits(0, {6'h3F, 1'b1, 8'hFF, 1'b0}, 10);
      begin
        repeat (70) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if ({valid_a, data_a, perr_a, ferr_a, ovr_a} !== 12'h000) begin errors++; $display("FAIL mid_reset_outputs: got v=%0b 0x%02h p=%0b f=%0b o=%0b want all 0", valid_a, data_a, perr_a, ferr_a, ovr_a); end
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    vectors++; if (valid_a !== 1'b0) begin errors++; $display("FAIL mid_aborted_lost: got %0b want 0", valid_a); end
    send_a(8'h3C);
    vectors++; if (valid_a !== 1'b1 || data_a !== 8'h3C || {perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL mid_next_frame: got v=%0b 0x%02h flags=%02b want v=1 0x3c 00", valid_a, data_a, {perr_a, ferr_a}); end
    pop_a();
  endtask

  task automatic test_wide();
    $display("tx 9N2 data=0x1ff");
    drive_bits(2, {4'hF, 2'b11, 9'h1FF, 1'b0}, 12);
    vectors++; if (valid_w !== 1'b1 || data_w !== 9'h1FF || ferr_w !== 1'b0) begin errors++; $display("FAIL wide_1ff: got v=%0b 0x%03h f=%0b want v=1 0x1ff f=0", valid_w, data_w, ferr_w); end
    rd_w = 1'b1; @(negedge clk); rd_w = 1'b0;
    $display("tx 9N2 data=0x0a5");
    drive_bits(2, {4'hF, 2'b11, 9'h0A5, 1'b0}, 12);
    vectors++; if (valid_w !== 1'b1 || data_w !== 9'h0A5) begin errors++; $display("FAIL wide_0a5: got v=%0b 0x%03h want v=1 0x0a5", valid_w, data_w); end
    rd_w = 1'b1; @(negedge clk); rd_w = 1'b0;
    vectors++; if (valid_w !== 1'b0) begin errors++; $display("FAIL wide_drain: got %0b want 0", valid_w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_back_to_back_pop();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver that succeeds the fixed 8N1 receiver. It supports configurable data width, optional parity, one or two stop bits, majority-vote sampling and glitch rejection. Received words are buffered with per-word error flags in a show-ahead FIFO, so a downstream consumer such as a display driver or command parser can drain them at its own pace. The block sits between the board RX pin and any logic that needs received bytes.

## Interface
- CLKS_PER_BIT, 217, clock cycles per UART bit; must be >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 4, receive buffer entries; power of 2, >= 2.

- i_clk  input  1  system clock; all logic rises on posedge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_uart_rx  input  1  asynchronous serial line; idles high.
- i_rd_en  input  1  pop head entry; ignored when o_rd_valid = 0.
- o_rd_valid  output  1  FIFO not empty.
- o_rd_data  output  DATA_BITS  head entry data, LSB = first received bit.
- o_rd_parity_err  output  1  head entry parity mismatch; always 0 when PARITY = 0.
- o_rd_frame_err  output  1  head entry had at least one stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.

## Operation
- **Input synchroniser:** i_uart_rx passes through 2 flops, both reset to 1. A third flop holds the previous synced value for edge detection.
- **Bit counter:** runs 0..CLKS_PER_BIT-1 within each bit. Let H = CLKS_PER_BIT/2 (integer division).
- **Bit decision:** the synced line is sampled at counter H-1, H and H+1. The bit value is the majority of the 3 samples, decided at H+1.
- **IDLE:** wait for a falling edge of the synced line (previous 1, current 0). On the edge, clear the counter and go to START. A line held low never retriggers.
- **START:** at the decision point, a majority of 1 means a glitch: return to IDLE with no FIFO write. A majority of 0 goes to DATA.
- **DATA:** DATA_BITS decisions, LSB first, into a shift register. Then go to PARITY if PARITY != 0, else STOP.
- **PARITY:** one decision.
  - Odd: the XOR of data and parity bit must be 1.
  - Even: that XOR must be 0.
  - A mismatch latches the parity error for this frame.
- **STOP:** STOP_BITS decisions. Any 0 latches the frame error. Frame data is still kept.
- **COMMIT:** one cycle after the last stop decision. Then return to IDLE immediately; the remainder of the stop bit is not waited out.
  - If the FIFO is not full, or a pop occurs in the same cycle, write {data, parity_err, frame_err}.
  - Otherwise drop the frame and pulse o_overrun. FIFO contents are unchanged.
- **FIFO:** show-ahead. The head entry's data and flags are valid whenever o_rd_valid = 1.
  - i_rd_en with o_rd_valid = 1 advances the head on that clock edge.
  - Simultaneous write and pop: count is unchanged, order is preserved.
  - Pointers wrap modulo FIFO_DEPTH. A count register of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- **Reset:** asserting i_rst at any time, including mid-frame, gives:
  - state IDLE, counters 0, synchroniser 1;
  - FIFO empty, o_rd_valid = 0, o_rd_data = 0, both flags 0, o_overrun = 0.
  - The aborted frame is lost. Reception resumes only on a new falling edge after reset deasserts.

## Timing
- Pin to synced line: 2 cycles.
- Let T be the cycle the falling edge is seen on the synced line, and N = DATA_BITS + (PARITY != 0) + STOP_BITS.
  - Start decision at T + H + 1.
  - Each later decision at +CLKS_PER_BIT intervals.
  - Last stop decision at T + H + 1 + N*CLKS_PER_BIT.
- COMMIT is the cycle after the last stop decision.
- o_rd_valid and head data update on the following edge, so valid appears 2 cycles after the last stop decision.
- o_overrun is high in exactly the cycle after COMMIT.
- A pop is reflected in o_rd_valid and o_rd_data on the next cycle.
- Back-to-back frames with zero idle time are received without loss, since IDLE is re-entered before the nominal end of the stop bit.

## Test plan
- **Basic 8N1:** CLKS_PER_BIT = 16, 8N1, send 0xA5 → o_rd_valid = 1, o_rd_data = 0xA5, both flags 0, latency matches Timing ±0 cycles. Pulse i_rd_en → o_rd_valid = 0.
- **Even parity:** PARITY = 2, send 0x03 with parity bit 1 (wrong) → data 0x03, o_rd_parity_err = 1. Send 0x07 with parity 1 → parity_err = 0.
- **Frame error / break:** send 0x55 with stop bit 0, then hold the line low for 30 bit times → one entry: 0x55, frame_err = 1. No further entries until the line returns high and falls again.
- **Glitches:** a 3-cycle low pulse on the line gives no entry. A single-cycle 1 glitch at a data-bit centre is out-voted by majority, so the word is correct.
- **Overrun and ordering:** FIFO_DEPTH = 4, send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back with no reads → exactly one o_overrun pulse, after frame 5. Reads return 0x11..0x44 in order. Repeat with a pop coincident with frame 5's COMMIT → no overrun, 0x55 stored.
- **Reset mid-frame:** assert i_rst at bit 4 of a frame → all outputs 0 immediately. The next full frame 0x3C is received correctly. DATA_BITS = 9 with STOP_BITS = 2, sending 0x1FF, returns 0x1FF.
